// File: rtl/zigzag_buffer_if.sv
// zigzag_buffer_if: row-in / beat-out handshake bundle for zigzag_buffer.
// slave is the buffer's view, master is the producer/consumer (or bench) view.
interface zigzag_buffer_if #(
   parameter int unsigned CW = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [8*CW-1:0]   in_row;
   logic              out_valid;
   logic              out_ready;
   logic [8*CW-1:0]   out_row;
   logic              out_sop;
   logic              out_eop;

   modport master (
      output in_valid, in_row, out_ready,
      input  in_ready, out_valid, out_row, out_sop, out_eop
   );

   modport slave (
      input  in_valid, in_row, out_ready,
      output in_ready, out_valid, out_row, out_sop, out_eop
   );
endinterface

// File: rtl/zigzag_buffer.sv
// zigzag_buffer: ping-pong 8x8 block buffer, raster rows in, zigzag beats out.
// Optional feature macro: ZZ_DC_DIFF_EN -- replaces the DC lane of beat 0 with the
// saturated difference from the previous emitted block's DC.
module zigzag_buffer #(
   parameter int unsigned CW = 10
) (
   input logic              clk,
   input logic              reset,
   zigzag_buffer_if.slave   bus
);
   localparam int unsigned RowW = 8 * CW;

   // Raster position of zigzag index k lives at bits [6k +: 6].
   localparam logic [383:0] ZzTable = {
      6'd63, 6'd62, 6'd55, 6'd47, 6'd54, 6'd61, 6'd60, 6'd53,
      6'd46, 6'd39, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd58,
      6'd51, 6'd44, 6'd37, 6'd30, 6'd23, 6'd15, 6'd22, 6'd29,
      6'd36, 6'd43, 6'd50, 6'd57, 6'd56, 6'd49, 6'd42, 6'd35,
      6'd28, 6'd21, 6'd14, 6'd7,  6'd6,  6'd13, 6'd20, 6'd27,
      6'd34, 6'd41, 6'd48, 6'd40, 6'd33, 6'd26, 6'd19, 6'd12,
      6'd5,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd24, 6'd17,
      6'd10, 6'd3,  6'd2,  6'd9,  6'd16, 6'd8,  6'd1,  6'd0
   };

   logic [CW-1:0]   mem_q [2][64];
   logic [CW-1:0]   mem_d [2][64];
   logic [1:0]      full_q, full_d;
   logic            wbank_q, wbank_d;
   logic            rbank_q, rbank_d;
   logic [2:0]      wrow_q, wrow_d;
   logic [2:0]      rbeat_q, rbeat_d;
   logic            out_valid_q, out_valid_d;
   logic            out_sop_q, out_sop_d;
   logic            out_eop_q, out_eop_d;
   logic [RowW-1:0] out_row_q, out_row_d;

   logic            in_ready;
   logic            wr_en;
   logic            rd_en;
   logic [5:0]      wr_addr;
   logic [5:0]      zz_addr;
   logic [RowW-1:0] rd_row;
   logic [CW-1:0]   dc_lane;

`ifdef ZZ_DC_DIFF_EN
   logic [CW-1:0]   dc_pred_q, dc_pred_d;
   logic [CW:0]     dc_diff;

   // DC DPCM: difference in CW+1 bits, clamped back into CW-bit signed range.
   always_comb begin
      dc_diff   = {rd_row[RowW-1], rd_row[RowW-1 -: CW]} - {dc_pred_q[CW-1], dc_pred_q};
      dc_pred_d = dc_pred_q;
      if (dc_diff[CW] != dc_diff[CW-1]) begin
         dc_lane = dc_diff[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
      end else begin
         dc_lane = dc_diff[CW-1:0];
      end
      if (rd_en && (rbeat_q == 3'd0)) begin
         dc_pred_d = rd_row[RowW-1 -: CW];
      end
   end

   // Predictor register.
   always_ff @(posedge clk) begin
      if (reset) dc_pred_q <= '0;
      else       dc_pred_q <= dc_pred_d;
   end
`else
   // Without DPCM the DC lane passes through untouched.
   always_comb begin
      dc_lane = rd_row[RowW-1 -: CW];
   end
`endif

   // Combinational zigzag gather from the draining bank.
   always_comb begin
      rd_row  = '0;
      zz_addr = '0;
      for (int j = 0; j < 8; j++) begin
         zz_addr = ZzTable[(8 * int'(rbeat_q) + j) * 6 +: 6];
         rd_row[(7 - j) * CW +: CW] = mem_q[rbank_q][zz_addr];
      end
   end

   // Handshakes, pointer/tag next state and output register loading.
   always_comb begin
      in_ready    = !full_q[wbank_q];
      wr_en       = bus.in_valid && in_ready;
      rd_en       = full_q[rbank_q] && (!out_valid_q || bus.out_ready);
      full_d      = full_q;
      wbank_d     = wbank_q;
      rbank_d     = rbank_q;
      wrow_d      = wrow_q;
      rbeat_d     = rbeat_q;
      out_valid_d = out_valid_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      out_row_d   = out_row_q;
      mem_d       = mem_q;
      wr_addr     = '0;

      if (wr_en) begin
         for (int c = 0; c < 8; c++) begin
            wr_addr = {wrow_q, 3'(c)};
            mem_d[wbank_q][wr_addr] = bus.in_row[(7 - c) * CW +: CW];
         end
         wrow_d = wrow_q + 3'd1;
         if (wrow_q == 3'd7) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
         end
      end

      // Write and read tag updates always hit different banks: a bank being
      // written is EMPTY, a bank being read is FULL.
      if (rd_en) begin
         out_valid_d = 1'b1;
         out_sop_d   = (rbeat_q == 3'd0);
         out_eop_d   = (rbeat_q == 3'd7);
         out_row_d   = rd_row;
         if (rbeat_q == 3'd0) begin
            out_row_d[RowW-1 -: CW] = dc_lane;
         end
         rbeat_d = rbeat_q + 3'd1;
         if (rbeat_q == 3'd7) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Control and output state.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_q      <= '0;
         wbank_q     <= 1'b0;
         rbank_q     <= 1'b0;
         wrow_q      <= '0;
         rbeat_q     <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_row_q   <= '0;
      end else begin
         full_q      <= full_d;
         wbank_q     <= wbank_d;
         rbank_q     <= rbank_d;
         wrow_q      <= wrow_d;
         rbeat_q     <= rbeat_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_row_q   <= out_row_d;
      end
   end

   // Bank storage; contents are only read once tagged FULL, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_sop   = out_sop_q;
   assign bus.out_eop   = out_eop_q;
endmodule

// File: tb/tb_zigzag_buffer.sv
// tb_zigzag_buffer: directed sequence with random block data, checked against a
// zigzag model built from a diagonal walk of the 8x8 block.
module tb_zigzag_buffer;
   localparam int CW = 10;

   typedef struct {
      logic [79:0] row;
      logic        sop;
      logic        eop;
      int          beat;
   } beat_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   zigzag_buffer_if #(.CW(CW)) bus ();

   zigzag_buffer #(.CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          zz_order [64];
   logic [79:0] rows_q [$];
   beat_t       exp_q [$];
   logic [79:0] row_src [8];
   logic        prev_stall = 1'b0;
   logic [79:0] prev_row;
   logic        prev_sop, prev_eop;
   logic        phase_on = 1'b0;
   int          phase_beats, first_cyc, last_cyc;
   logic [9:0]  last_dc;
`ifdef ZZ_DC_DIFF_EN
   int          pred = 0;
`endif

   task automatic chk_row(string tag, logic [79:0] got, logic [79:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_bit(string tag, logic got, logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_int(string tag, int got, int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] rand_row();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[79:0];
   endfunction

   // Model: eight collected raster rows become eight zigzag beats.
   task automatic model_block();
      logic [9:0]  coef [64];
      logic [79:0] r;
      beat_t       b;
      int          d;
      for (int i = 0; i < 64; i++) coef[i] = rows_q[i / 8][(7 - (i % 8)) * 10 +: 10];
      rows_q.delete();
      d = int'($signed(coef[0]));
`ifdef ZZ_DC_DIFF_EN
      d = d - pred;
      if (d > 511) d = 511;
      if (d < -512) d = -512;
      pred = int'($signed(coef[0]));
`endif
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 8; j++) r[(7 - j) * 10 +: 10] = coef[zz_order[8 * k + j]];
         if (k == 0) r[79:70] = d[9:0];
         b.row  = r;
         b.sop  = (k == 0);
         b.eop  = (k == 7);
         b.beat = k;
         exp_q.push_back(b);
      end
   endtask

   // Called at a falling edge with inputs set; observes this cycle, then advances one.
   task automatic tick();
      beat_t e;
      if (reset) begin
         rows_q.delete();
         exp_q.delete();
         prev_stall = 1'b0;
`ifdef ZZ_DC_DIFF_EN
         pred = 0;
`endif
      end else begin
         if (prev_stall) begin
            chk_bit("stall_valid", bus.out_valid, 1'b1);
            chk_row("stall_row", bus.out_row, prev_row);
            chk_bit("stall_sop", bus.out_sop, prev_sop);
            chk_bit("stall_eop", bus.out_eop, prev_eop);
         end
         if (bus.in_valid && bus.in_ready) begin
            rows_q.push_back(bus.in_row);
            if (rows_q.size() == 8) model_block();
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk_bit("spurious_beat", bus.out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk_row("beat_row", bus.out_row, e.row);
               chk_bit("beat_sop", bus.out_sop, e.sop);
               chk_bit("beat_eop", bus.out_eop, e.eop);
               if (e.sop) last_dc = bus.out_row[79:70];
               if (phase_on) begin
                  if (phase_beats == 0) first_cyc = cyc;
                  last_cyc = cyc;
                  phase_beats++;
               end
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_row   = bus.out_row;
         prev_sop   = bus.out_sop;
         prev_eop   = bus.out_eop;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic send_rows(int n, int budget, bit chk_rdy, bit use_src);
      int  sent = 0;
      int  t = 0;
      bit  acc;
      bus.in_valid = 1'b1;
      bus.in_row   = use_src ? row_src[0] : rand_row();
      while (sent < n && t < budget) begin
         if (chk_rdy) chk_bit("in_ready_cont", bus.in_ready, 1'b1);
         acc = bus.in_ready;
         tick();
         if (acc) begin
            sent++;
            if (sent < n) bus.in_row = use_src ? row_src[sent] : rand_row();
         end
         t++;
      end
      bus.in_valid = 1'b0;
      if (sent < n) chk_int("send_timeout", sent, n);
   endtask

   task automatic drain(int budget);
      int t = 0;
      bus.out_ready = 1'b1;
      while ((exp_q.size() > 0 || bus.out_valid) && t < budget) begin
         tick();
         t++;
      end
      chk_bit("drain_valid", bus.out_valid, 1'b0);
      chk_int("drain_pending", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(string tag);
      chk_bit({tag, "_valid"}, bus.out_valid, 1'b0);
      chk_bit({tag, "_sop"}, bus.out_sop, 1'b0);
      chk_bit({tag, "_eop"}, bus.out_eop, 1'b0);
      chk_row({tag, "_row"}, bus.out_row, 80'd0);
      chk_bit({tag, "_in_ready"}, bus.in_ready, 1'b1);
   endtask

   task automatic dc_block(logic [9:0] dc);
      for (int r = 0; r < 8; r++) row_src[r] = rand_row();
      row_src[0][79:70] = dc;
      send_rows(8, 20, 1'b0, 1'b1);
      drain(30);
   endtask

   initial begin
      int idx, t;
      logic [79:0] exp_b;
      // Zigzag order from a diagonal walk, alternating direction per anti-diagonal.
      idx = 0;
      for (int s = 0; s < 15; s++) begin
         if (s % 2 == 0) begin
            for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
               zz_order[idx] = 8 * r + (s - r);
               idx++;
            end
         end else begin
            for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
               zz_order[idx] = 8 * r + (s - r);
               idx++;
            end
         end
      end

      bus.in_valid  = 1'b0;
      bus.in_row    = '0;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      @(negedge clk);
      tick();
      tick();
      check_reset_outputs("reset");
      reset = 1'b0;

      // Ramp block: coefficient (r,c) = 8r+c.
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) row_src[r][(7 - c) * 10 +: 10] = 10'(8 * r + c);
      send_rows(8, 20, 1'b0, 1'b1);
      chk_bit("lat_pre", bus.out_valid, 1'b0);
      tick();
      chk_bit("lat_first", bus.out_valid, 1'b1);
      exp_b = {10'd0, 10'd1, 10'd8, 10'd16, 10'd9, 10'd2, 10'd3, 10'd10};
      chk_row("ramp_beat0", bus.out_row, exp_b);
      chk_bit("ramp_sop0", bus.out_sop, 1'b1);
      for (int k = 0; k < 7; k++) tick();
      exp_b = {10'd53, 10'd60, 10'd61, 10'd54, 10'd47, 10'd55, 10'd62, 10'd63};
      chk_row("ramp_beat7", bus.out_row, exp_b);
      chk_bit("ramp_eop7", bus.out_eop, 1'b1);
      drain(20);

      // Three back-to-back random blocks.
      phase_on = 1'b1;
      phase_beats = 0;
      send_rows(24, 40, 1'b1, 1'b0);
      drain(40);
      phase_on = 1'b0;
      chk_int("b2b_beats", phase_beats, 24);
      chk_int("b2b_gapless", last_cyc - first_cyc + 1, 24);

      // Short stall on beat 2.
      send_rows(8, 20, 1'b0, 1'b0);
      t = 0;
      while (!(bus.out_valid && exp_q.size() > 0 && exp_q[0].beat == 2) && t < 20) begin
         tick();
         t++;
      end
      chk_bit("stall_b2_reached", bus.out_valid, 1'b1);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      drain(30);

      // Long stall: both banks fill, input blocks until first block's beat 7 loads.
      bus.out_ready = 1'b0;
      send_rows(16, 40, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_row   = rand_row();
      for (int k = 0; k < 10; k++) begin
         chk_bit("bp_in_ready_low", bus.in_ready, 1'b0);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      t = 0;
      while (t < 20) begin
         if (bus.out_valid && exp_q.size() > 0 && exp_q[0].eop) begin
            chk_bit("bp_in_ready_back", bus.in_ready, 1'b1);
            break;
         end
         chk_bit("bp_in_ready_wait", bus.in_ready, 1'b0);
         tick();
         t++;
      end
      chk_int("bp_recover_bound", (t < 20) ? 1 : 0, 1);
      drain(30);

      // Reset mid-drain with a partial block A, then block B alone.
      bus.out_ready = 1'b0;
      send_rows(8, 20, 1'b0, 1'b0);
      send_rows(5, 20, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      check_reset_outputs("mid_reset");
      send_rows(8, 20, 1'b0, 1'b0);
      chk_bit("b_lat_pre", bus.out_valid, 1'b0);
      tick();
      chk_bit("b_lat_first", bus.out_valid, 1'b1);
      chk_bit("b_sop", bus.out_sop, 1'b1);
      drain(20);

      // DC lane behaviour from a fresh predictor.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      dc_block(10'd100);
      chk_row("dc_first", 80'(last_dc), 80'd100);
      dc_block(10'd90);
`ifdef ZZ_DC_DIFF_EN
      chk_row("dc_second", 80'(last_dc), 80'h3F6);
`else
      chk_row("dc_second", 80'(last_dc), 80'd90);
`endif
      dc_block(10'h200);
      chk_row("dc_neg_min", 80'(last_dc), 80'h200);
      dc_block(10'h1FF);
      chk_row("dc_pos_max", 80'(last_dc), 80'h1FF);

      chk_int("final_pending", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/zigzag_buffer.md
# zigzag_buffer

Upstream neighbour of `RLE_top` in the JPEG encoder datapath. It accepts an 8×8 block of quantized coefficients in raster order, one 80-bit row per beat, and re-emits the block as eight 80-bit beats in JPEG zigzag order. A ping-pong pair of block banks lets a new block fill while the previous one drains, so a continuous stream needs no bubbles. Its output row format matches the 80-bit row input `RLE_top` consumes.

## Interface
- `CW`, 10: coefficient width in bits, signed two's complement. Each row carries 8 lanes, so a row is 8*CW = 80 bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_row` carries a valid raster row.
- `in_ready`  out  1: block can accept a row this cycle.
- `in_row`  in  80: raster row r; lane c = coefficient (r,c); lane 0 = bits [79:70], lane 7 = bits [9:0].
- `out_valid`  out  1: `out_row` holds a valid zigzag beat.
- `out_ready`  in  1: downstream accepts the beat this cycle.
- `out_row`  out  80: zigzag beat k; lane j = zigzag index 8k+j; lane order as for `in_row`.
- `out_sop`  out  1: high with beat 0 of each block.
- `out_eop`  out  1: high with beat 7 of each block.

## Operation
- Two banks, each 64×CW, each tagged EMPTY or FULL. Pointers: `wbank`, `wrow` (0..7), `rbank`, `rbeat` (0..7).
- Write side:
  - A row is accepted when `in_valid && in_ready`. It is stored as raster entries 8*wrow..8*wrow+7 of `wbank`, and `wrow` increments.
  - When `wrow`=7 is accepted, `wbank` becomes FULL, `wrow` wraps to 0, and `wbank` toggles.
  - `in_ready` = (`wbank` is EMPTY).
- Read side:
  - A beat is produced when `rbank` is FULL and the output register is empty or being accepted (`!out_valid || out_ready`).
  - Producing a beat loads `out_row` with the zigzag entries for `rbeat`, using the standard order: 0,1,8,16,9,2,3,10 / 17,24,32,25,18,11,4,5 / … / 53,60,61,54,47,55,62,63.
  - `rbeat` then increments. After beat 7 is loaded, `rbank` becomes EMPTY and toggles.
- Stalls: while `out_valid && !out_ready`, `out_row`, `out_sop` and `out_eop` hold stable.
- Simultaneous events: a bank filling and the other bank freeing in the same cycle both take effect; the write-side and read-side tag updates never target the same bank in one cycle.
- Reset: clears both tags to EMPTY and sets all pointers to 0. It also drives `out_valid`, `out_sop` and `out_eop` low, `out_row` to 0, and `in_ready` high after the edge. A partially written block is discarded, and reset mid-drain abandons the remaining beats.

## Timing
- Latency: beat 0 appears with `out_valid`=1 in the cycle after the 8th row of a block is accepted.
- Throughput: one row in and one beat out per cycle. With `out_ready` held high and `in_valid` continuous, `in_ready` never drops and `out_valid` stays high from the first block onward.
- Backpressure: when both banks are FULL, `in_ready`=0 until the draining bank's beat 7 is loaded.
- Memory reads are combinational from bank registers into the output register; there are no other pipeline stages.

## Configuration
- `ZZ_DC_DIFF_EN` defined:
  - Lane 0 of beat 0 carries the DC DPCM value: DC minus the previous block's DC, computed in CW+1 bits and saturated to [-512, 511].
  - The predictor register holds the raw DC of the last emitted block. It updates when beat 0 is loaded and resets to 0.
- Undefined: lane 0 of beat 0 carries the raw DC, and there is no predictor register.

## Test plan
- Ramp block, coefficient (r,c) = 8r+c, `out_ready`=1:
  - beat 0 = 0,1,8,16,9,2,3,10;
  - beat 7 = 53,60,61,54,47,55,62,63;
  - `out_sop` on beat 0 and `out_eop` on beat 7;
  - first beat one cycle after the 8th row.
- Three back-to-back blocks, continuous `in_valid`: `in_ready` stays 1 and 24 consecutive valid beats are emitted with no gaps.
- Backpressure:
  - drop `out_ready` for 3 cycles at beat 2: beat 2 is held unchanged;
  - drop `out_ready` for 10 cycles: `in_ready` falls after the second block fills and recovers after beat 7 of the first block is taken.
- Reset after 5 rows of block A:
  - outputs return to their reset values;
  - a following block B emits only B data, starting 1 cycle after B's 8th row.
- `ZZ_DC_DIFF_EN` defined:
  - DCs 100 then 90 → lane 0 = 100, then -10 (0x3F6);
  - DCs -512 then 511 → second lane 0 saturates to 511.
- `ZZ_DC_DIFF_EN` undefined: DCs 100 then 90 → lane 0 = 100, then 90.
